// File: rtl/axi_lite_gpio_sub_pkg.sv
// Shared types, register map and decode helpers for the AXI-Lite GPIO subordinate.
package axi_lite_gpio_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_t;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } wr_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

    // Byte offsets of the register map (only addr[7:0] is decoded)
    localparam logic [7:0] OFF_LED      = 8'h00;
    localparam logic [7:0] OFF_SW       = 8'h04;
    localparam logic [7:0] OFF_BTN      = 8'h08;
    localparam logic [7:0] OFF_BTN_EDGE = 8'h0C;
    localparam logic [7:0] OFF_IRQ_EN   = 8'h10;

    // Word indices (addr[7:2]) used by the decoders
    localparam logic [5:0] IDX_LED      = OFF_LED[7:2];
    localparam logic [5:0] IDX_SW       = OFF_SW[7:2];
    localparam logic [5:0] IDX_BTN      = OFF_BTN[7:2];
    localparam logic [5:0] IDX_BTN_EDGE = OFF_BTN_EDGE[7:2];
    localparam logic [5:0] IDX_IRQ_EN   = OFF_IRQ_EN[7:2];

    // Expand the 4 byte strobes into a 32-bit bit mask
    function automatic logic [31:0] strb_mask(input logic [3:0] strb);
        logic [31:0] mask;
        mask = 32'h0000_0000;
        for (int b = 0; b < 4; b++) begin
            mask[8*b +: 8] = {8{strb[b]}};
        end
        return mask;
    endfunction

    // Response for an access to a word index; IRQ_EN only exists when the IRQ block is built
    function automatic resp_t decode_resp(input logic [5:0] idx, input logic irq_present);
        resp_t resp;
        case (idx)
            IDX_LED, IDX_SW, IDX_BTN, IDX_BTN_EDGE: resp = OKAY;
            IDX_IRQ_EN: resp = irq_present ? OKAY : SLVERR;
            default:    resp = SLVERR;
        endcase
        return resp;
    endfunction

endpackage

// File: rtl/axi_lite_gpio_sub_if.sv
// AXI-Lite bus bundle (AW/W/B/AR/R) with manager and subordinate views.
interface axi_lite_gpio_sub_if #(
    parameter int ID_WIDTH   = 1,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    awvalid;
    logic                    awready;
    logic [ID_WIDTH-1:0]     awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    wvalid;
    logic                    wready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    bvalid;
    logic                    bready;
    logic [ID_WIDTH-1:0]     bid;
    logic [1:0]              bresp;
    logic                    arvalid;
    logic                    arready;
    logic [ID_WIDTH-1:0]     arid;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    rvalid;
    logic                    rready;
    logic [ID_WIDTH-1:0]     rid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;

    modport master (
        output awvalid, awid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, arid, araddr, arprot, rready,
        input  awready, wready, bvalid, bid, bresp, arready, rvalid, rid, rdata, rresp
    );

    modport slave (
        input  awvalid, awid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, arid, araddr, arprot, rready,
        output awready, wready, bvalid, bid, bresp, arready, rvalid, rid, rdata, rresp
    );
endinterface

// File: rtl/axi_lite_gpio_sub_sync_edge.sv
// Two-flop synchroniser for asynchronous board inputs with rising-edge detect.
module gpio_sync_edge #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out,
    output logic [WIDTH-1:0] rise
);
    logic [WIDTH-1:0] meta_r;
    logic [WIDTH-1:0] sync_r;
    logic [WIDTH-1:0] prev_r;

    // Metastability chain plus a one-cycle-delayed copy for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_r <= '0;
            sync_r <= '0;
            prev_r <= '0;
        end else begin
            meta_r <= async_in;
            sync_r <= meta_r;
            prev_r <= sync_r;
        end
    end

    assign sync_out = sync_r;
    assign rise     = sync_r & ~prev_r;
endmodule

// File: rtl/axi_lite_gpio_sub.sv
// AXI-Lite subordinate exposing LEDs, switches, buttons and sticky button edges.
// Optional interrupt block (IRQ_EN register and irq_o) is built when GPIO_IRQ_EN is defined.
module axi_lite_gpio_sub
    import axi_lite_gpio_pkg::*;
#(
    parameter int ID_WIDTH   = 1,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LED_WIDTH  = 8,
    parameter int SW_WIDTH   = 8,
    parameter int BTN_WIDTH  = 5
) (
    input  logic                 aclk,
    input  logic                 areset,
    axi_lite_gpio_sub_if.slave   s_axi,
    output logic [LED_WIDTH-1:0] led_o,
    input  logic [SW_WIDTH-1:0]  sw_i,
    input  logic [BTN_WIDTH-1:0] btn_i
`ifdef GPIO_IRQ_EN
    ,
    output logic                 irq_o
`endif
);
    if (DATA_WIDTH != 32) begin : g_data_width_check
        $error("axi_lite_gpio_sub: DATA_WIDTH must be 32");
    end

`ifdef GPIO_IRQ_EN
    localparam logic IRQ_PRESENT = 1'b1;
    logic [BTN_WIDTH-1:0] irq_en_r;
    logic                 irq_r;
    logic [31:0]          irq_en_merge_s;
`else
    localparam logic IRQ_PRESENT = 1'b0;
`endif

    // Write channel state
    wr_state_t            wr_state_r;
    logic                 aw_held_r, w_held_r, awready_r, wready_r, bvalid_r;
    logic [5:0]           aw_idx_r;
    logic [ID_WIDTH-1:0]  aw_id_r, bid_r;
    logic [31:0]          w_data_r;
    logic [3:0]           w_strb_r;
    resp_t                bresp_r;
    // Read channel state
    rd_state_t            rd_state_r;
    logic                 arready_r, rvalid_r;
    logic [ID_WIDTH-1:0]  rid_r;
    logic [31:0]          rdata_r;
    resp_t                rresp_r;
    // GPIO registers
    logic [LED_WIDTH-1:0] led_r;
    logic [BTN_WIDTH-1:0] edge_r;
    logic [SW_WIDTH-1:0]  sw_sync_s, sw_rise_unused_s;
    logic [BTN_WIDTH-1:0] btn_sync_s, btn_rise_s;
    // Combinational decode
    logic                 aw_hs_s, w_hs_s, commit_s, ar_hs_s;
    logic [5:0]           cur_idx_s;
    logic [ID_WIDTH-1:0]  cur_id_s;
    logic [31:0]          cur_data_s, wmask_s, wbits_s, led_merge_s, rd_val_s;
    logic [3:0]           cur_strb_s;
    logic [BTN_WIDTH-1:0] w1c_s;
    resp_t                wr_resp_s, rd_resp_s;
    logic                 unused_s;

    gpio_sync_edge #(.WIDTH(SW_WIDTH)) u_sw_sync (
        .clk(aclk), .rst(areset), .async_in(sw_i), .sync_out(sw_sync_s), .rise(sw_rise_unused_s)
    );

    gpio_sync_edge #(.WIDTH(BTN_WIDTH)) u_btn_sync (
        .clk(aclk), .rst(areset), .async_in(btn_i), .sync_out(btn_sync_s), .rise(btn_rise_s)
    );

    // Write decode: merge a beat arriving this cycle with any beat already held
    always_comb begin
        aw_hs_s = 1'b0;
        w_hs_s  = 1'b0;
        if (wr_state_r == W_IDLE) begin
            aw_hs_s = s_axi.awvalid & awready_r;
            w_hs_s  = s_axi.wvalid & wready_r;
        end else begin
            aw_hs_s = 1'b0;
            w_hs_s  = 1'b0;
        end
        cur_idx_s   = aw_hs_s ? s_axi.awaddr[7:2] : aw_idx_r;
        cur_id_s    = aw_hs_s ? s_axi.awid : aw_id_r;
        cur_data_s  = w_hs_s ? s_axi.wdata : w_data_r;
        cur_strb_s  = w_hs_s ? s_axi.wstrb : w_strb_r;
        commit_s    = (wr_state_r == W_IDLE) && (aw_held_r || aw_hs_s) && (w_held_r || w_hs_s);
        wmask_s     = strb_mask(cur_strb_s);
        wbits_s     = cur_data_s & wmask_s;
        wr_resp_s   = decode_resp(cur_idx_s, IRQ_PRESENT);
        led_merge_s = (32'(led_r) & ~wmask_s) | wbits_s;
        if (commit_s && (cur_idx_s == IDX_BTN_EDGE)) begin
            w1c_s = wbits_s[BTN_WIDTH-1:0];
        end else begin
            w1c_s = '0;
        end
    end

    // Write FSM: collect AW and W independently, then hold the response until bready
    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_state_r <= W_IDLE;
            aw_held_r  <= 1'b0;
            w_held_r   <= 1'b0;
            aw_idx_r   <= 6'd0;
            aw_id_r    <= '0;
            w_data_r   <= 32'h0;
            w_strb_r   <= 4'h0;
            awready_r  <= 1'b1;
            wready_r   <= 1'b1;
            bvalid_r   <= 1'b0;
            bid_r      <= '0;
            bresp_r    <= OKAY;
        end else begin
            case (wr_state_r)
                W_IDLE: begin
                    if (commit_s) begin
                        wr_state_r <= W_RESP;
                        aw_held_r  <= 1'b0;
                        w_held_r   <= 1'b0;
                        awready_r  <= 1'b0;
                        wready_r   <= 1'b0;
                        bvalid_r   <= 1'b1;
                        bid_r      <= cur_id_s;
                        bresp_r    <= wr_resp_s;
                    end else begin
                        if (aw_hs_s) begin
                            aw_held_r <= 1'b1;
                            aw_idx_r  <= s_axi.awaddr[7:2];
                            aw_id_r   <= s_axi.awid;
                            awready_r <= 1'b0;
                        end
                        if (w_hs_s) begin
                            w_held_r <= 1'b1;
                            w_data_r <= s_axi.wdata;
                            w_strb_r <= s_axi.wstrb;
                            wready_r <= 1'b0;
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi.bready) begin
                        wr_state_r <= W_IDLE;
                        bvalid_r   <= 1'b0;
                        awready_r  <= 1'b1;
                        wready_r   <= 1'b1;
                    end
                end
                default: begin
                    wr_state_r <= W_IDLE;
                    bvalid_r   <= 1'b0;
                    awready_r  <= 1'b1;
                    wready_r   <= 1'b1;
                end
            endcase
        end
    end

    // LED storage and sticky edge capture; a new rising edge beats a same-cycle clear
    always_ff @(posedge aclk) begin
        if (areset) begin
            led_r  <= '0;
            edge_r <= '0;
        end else begin
            if (commit_s && (cur_idx_s == IDX_LED)) begin
                led_r <= led_merge_s[LED_WIDTH-1:0];
            end
            edge_r <= (edge_r & ~w1c_s) | btn_rise_s;
        end
    end

`ifdef GPIO_IRQ_EN
    assign irq_en_merge_s = (32'(irq_en_r) & ~wmask_s) | wbits_s;

    // Interrupt enable register and registered interrupt request
    always_ff @(posedge aclk) begin
        if (areset) begin
            irq_en_r <= '0;
            irq_r    <= 1'b0;
        end else begin
            if (commit_s && (cur_idx_s == IDX_IRQ_EN)) begin
                irq_en_r <= irq_en_merge_s[BTN_WIDTH-1:0];
            end
            irq_r <= |(edge_r & irq_en_r);
        end
    end

    assign irq_o = irq_r;
`endif

    // Read decode: data and response for the address presented on AR
    always_comb begin
        rd_val_s = 32'h0;
        case (s_axi.araddr[7:2])
            IDX_LED:      rd_val_s = 32'(led_r);
            IDX_SW:       rd_val_s = 32'(sw_sync_s);
            IDX_BTN:      rd_val_s = 32'(btn_sync_s);
            IDX_BTN_EDGE: rd_val_s = 32'(edge_r);
`ifdef GPIO_IRQ_EN
            IDX_IRQ_EN:   rd_val_s = 32'(irq_en_r);
`endif
            default:      rd_val_s = 32'h0;
        endcase
        ar_hs_s   = (rd_state_r == R_IDLE) & s_axi.arvalid & arready_r;
        rd_resp_s = decode_resp(s_axi.araddr[7:2], IRQ_PRESENT);
    end

    // Read FSM: capture data at the AR handshake and hold it until rready
    always_ff @(posedge aclk) begin
        if (areset) begin
            rd_state_r <= R_IDLE;
            arready_r  <= 1'b1;
            rvalid_r   <= 1'b0;
            rid_r      <= '0;
            rdata_r    <= 32'h0;
            rresp_r    <= OKAY;
        end else begin
            case (rd_state_r)
                R_IDLE: begin
                    if (ar_hs_s) begin
                        rd_state_r <= R_DATA;
                        arready_r  <= 1'b0;
                        rvalid_r   <= 1'b1;
                        rid_r      <= s_axi.arid;
                        rdata_r    <= rd_val_s;
                        rresp_r    <= rd_resp_s;
                    end
                end
                R_DATA: begin
                    if (s_axi.rready) begin
                        rd_state_r <= R_IDLE;
                        arready_r  <= 1'b1;
                        rvalid_r   <= 1'b0;
                    end
                end
                default: begin
                    rd_state_r <= R_IDLE;
                    arready_r  <= 1'b1;
                    rvalid_r   <= 1'b0;
                end
            endcase
        end
    end

    assign s_axi.awready = awready_r;
    assign s_axi.wready  = wready_r;
    assign s_axi.bvalid  = bvalid_r;
    assign s_axi.bid     = bid_r;
    assign s_axi.bresp   = bresp_r;
    assign s_axi.arready = arready_r;
    assign s_axi.rvalid  = rvalid_r;
    assign s_axi.rid     = rid_r;
    assign s_axi.rdata   = rdata_r;
    assign s_axi.rresp   = rresp_r;
    assign led_o         = led_r;

    // Protection bits, undecoded address bits and switch edges have no function here
    assign unused_s = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr, s_axi.araddr, sw_rise_unused_s};
endmodule

// File: tb/tb_axi_lite_gpio_sub.sv
// Self-checking bench for axi_lite_gpio_sub; randomized traffic against a register-map model.
// Define GPIO_IRQ_EN for both bench and RTL to cover the interrupt block.
module tb_axi_lite_gpio_sub;
    localparam int ID_W  = 1;
    localparam int LED_W = 8;
    localparam int SW_W  = 8;
    localparam int BTN_W = 5;

    logic             aclk;
    logic             areset;
    logic [LED_W-1:0] led_o;
    logic [SW_W-1:0]  sw_i;
    logic [BTN_W-1:0] btn_i;
`ifdef GPIO_IRQ_EN
    logic             irq_o;
`endif

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [LED_W-1:0] m_led;
    logic [SW_W-1:0]  m_sw;
    logic [BTN_W-1:0] m_btn;
    logic [BTN_W-1:0] m_edge;
    logic [BTN_W-1:0] m_irq_en;

    axi_lite_gpio_sub_if #(.ID_WIDTH(ID_W), .ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    axi_lite_gpio_sub #(
        .ID_WIDTH(ID_W), .ADDR_WIDTH(32), .DATA_WIDTH(32),
        .LED_WIDTH(LED_W), .SW_WIDTH(SW_W), .BTN_WIDTH(BTN_W)
    ) dut (
        .aclk(aclk),
        .areset(areset),
        .s_axi(bus),
        .led_o(led_o),
        .sw_i(sw_i),
        .btn_i(btn_i)
`ifdef GPIO_IRQ_EN
        ,
        .irq_o(irq_o)
`endif
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge_bytes(input logic [31:0] old, input logic [31:0] data,
                                                input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) r[8*b +: 8] = data[8*b +: 8];
        end
        return r;
    endfunction

    // Expected read data/response from the register map
    function automatic void model_read(input logic [31:0] addr, output logic [31:0] d,
                                       output logic [1:0] r);
        int idx;
        idx = int'(addr[7:2]);
        d = 32'h0;
        r = 2'b00;
        case (idx)
            0: d = 32'(m_led);
            1: d = 32'(m_sw);
            2: d = 32'(m_btn);
            3: d = 32'(m_edge);
`ifdef GPIO_IRQ_EN
            4: d = 32'(m_irq_en);
`endif
            default: r = 2'b10;
        endcase
    endfunction

    // Apply a write to the model and return the expected response
    function automatic logic [1:0] model_write(input logic [31:0] addr, input logic [31:0] data,
                                               input logic [3:0] strb);
        int idx;
        logic [31:0] wbits;
        idx = int'(addr[7:2]);
        wbits = merge_bytes(32'h0, data, strb);
        case (idx)
            0: m_led = LED_W'(merge_bytes(32'(m_led), data, strb));
            1, 2: ;
            3: m_edge = m_edge & ~BTN_W'(wbits);
`ifdef GPIO_IRQ_EN
            4: m_irq_en = BTN_W'(merge_bytes(32'(m_irq_en), data, strb));
`endif
            default: return 2'b10;
        endcase
        return 2'b00;
    endfunction

    // Full write transaction; call at a negedge, returns at a negedge
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_delay, input int w_delay, input int b_delay,
                             input logic [1:0] exp_resp);
        logic aw_done, w_done, aw_fire, w_fire;
        logic [ID_W-1:0] id;
        int k;
        id = ID_W'($urandom_range(0, 1));
        aw_done = 1'b0;
        w_done  = 1'b0;
        k = 0;
        bus.awaddr = addr;
        bus.awid   = id;
        bus.wdata  = data;
        bus.wstrb  = strb;
        while (!(aw_done && w_done) && k < 40) begin
            if (!aw_done && k >= aw_delay) bus.awvalid = 1'b1;
            if (!w_done && k >= w_delay) bus.wvalid = 1'b1;
            aw_fire = bus.awvalid && bus.awready;
            w_fire  = bus.wvalid && bus.wready;
            @(negedge aclk);
            if (aw_fire) begin bus.awvalid = 1'b0; aw_done = 1'b1; end
            if (w_fire) begin bus.wvalid = 1'b0; w_done = 1'b1; end
            if (aw_done && !w_done) check("wr_awready_held", 32'(bus.awready), 32'h0);
            if (w_done && !aw_done) check("wr_wready_held", 32'(bus.wready), 32'h0);
            if (!(aw_done && w_done)) check("wr_bvalid_early", 32'(bus.bvalid), 32'h0);
            k++;
        end
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        check("wr_handshake_timeout", 32'(aw_done && w_done), 32'h1);
        for (int i = 0; i <= b_delay; i++) begin
            check("wr_bvalid", 32'(bus.bvalid), 32'h1);
            check("wr_bid", 32'(bus.bid), 32'(id));
            check("wr_bresp", 32'(bus.bresp), 32'(exp_resp));
            if (i == b_delay) bus.bready = 1'b1;
            @(negedge aclk);
        end
        bus.bready = 1'b0;
        check("wr_bvalid_drop", 32'(bus.bvalid), 32'h0);
        check("wr_awready_back", 32'(bus.awready), 32'h1);
        check("wr_wready_back", 32'(bus.wready), 32'h1);
    endtask

    // Full read transaction; call at a negedge, returns at a negedge
    task automatic axi_read(input logic [31:0] addr, input int r_delay, input logic [31:0] exp_d,
                            input logic [1:0] exp_r);
        logic [ID_W-1:0] id;
        int k;
        id = ID_W'($urandom_range(0, 1));
        bus.arvalid = 1'b1;
        bus.araddr  = addr;
        bus.arid    = id;
        k = 0;
        while (bus.arready !== 1'b1 && k < 20) begin
            @(negedge aclk);
            k++;
        end
        check("rd_arready", 32'(bus.arready), 32'h1);
        @(negedge aclk);
        bus.arvalid = 1'b0;
        check("rd_arready_low", 32'(bus.arready), 32'h0);
        for (int i = 0; i <= r_delay; i++) begin
            check("rd_rvalid", 32'(bus.rvalid), 32'h1);
            check("rd_rdata", bus.rdata, exp_d);
            check("rd_rid", 32'(bus.rid), 32'(id));
            check("rd_rresp", 32'(bus.rresp), 32'(exp_r));
            if (i == r_delay) bus.rready = 1'b1;
            @(negedge aclk);
        end
        bus.rready = 1'b0;
        check("rd_rvalid_drop", 32'(bus.rvalid), 32'h0);
        check("rd_arready_back", 32'(bus.arready), 32'h1);
    endtask

    task automatic model_check_read(input logic [31:0] addr, input int r_delay);
        logic [31:0] d;
        logic [1:0]  r;
        model_read(addr, d, r);
        axi_read(addr, r_delay, d, r);
    endtask

    task automatic model_do_write(input logic [31:0] addr, input logic [31:0] data,
                                  input logic [3:0] strb, input int awd, input int wd, input int bd);
        logic [1:0] r;
        r = model_write(addr, data, strb);
        axi_write(addr, data, strb, awd, wd, bd, r);
        check("led_o", 32'(led_o), 32'(m_led));
    endtask

    // Change buttons and let the change pass the synchroniser
    task automatic set_buttons(input logic [BTN_W-1:0] v);
        btn_i = v;
        repeat (5) @(negedge aclk);
        m_edge = m_edge | (v & ~m_btn);
        m_btn = v;
    endtask

    // New button edge captured on the same clock as a W1C write to the edge register
    task automatic press_with_w1c(input logic [BTN_W-1:0] v, input logic [31:0] clr);
        btn_i = v;
        @(negedge aclk);
        @(negedge aclk);
        axi_write(32'h0000_000C, clr, 4'hF, 0, 0, 0, 2'b00);
        m_edge = (m_edge & ~BTN_W'(clr)) | (v & ~m_btn);
        m_btn = v;
    endtask

    task automatic model_reset();
        m_led = '0; m_sw = '0; m_btn = '0; m_edge = '0; m_irq_en = '0;
    endtask

    logic [7:0]  offs [8];
    logic [31:0] addr_v;

    initial begin
        offs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h20, 8'hFC};
        bus.awvalid = 1'b0; bus.awid = '0; bus.awaddr = 32'h0; bus.awprot = 3'b000;
        bus.wvalid = 1'b0; bus.wdata = 32'h0; bus.wstrb = 4'h0; bus.bready = 1'b0;
        bus.arvalid = 1'b0; bus.arid = '0; bus.araddr = 32'h0; bus.arprot = 3'b000;
        bus.rready = 1'b0;
        sw_i = '0;
        btn_i = '0;
        areset = 1'b1;
        model_reset();

        // Reset state
        repeat (3) begin
            @(negedge aclk);
            check("rst_bvalid", 32'(bus.bvalid), 32'h0);
            check("rst_rvalid", 32'(bus.rvalid), 32'h0);
        end
        check("rst_awready", 32'(bus.awready), 32'h1);
        check("rst_wready", 32'(bus.wready), 32'h1);
        check("rst_arready", 32'(bus.arready), 32'h1);
        check("rst_bresp", 32'(bus.bresp), 32'h0);
        check("rst_rdata", bus.rdata, 32'h0);
        check("rst_led", 32'(led_o), 32'h0);
        areset = 1'b0;
        @(negedge aclk);
        axi_read(32'h0000_0000, 0, 32'h0, 2'b00);

        // AW first, W three cycles later
        model_do_write(32'h0000_0000, 32'h0000_00A5, 4'hF, 0, 3, 0);
        check("led_a5", 32'(led_o), 32'h0000_00A5);
        // W first, AW later, delayed bready
        model_do_write(32'h0000_0000, 32'h0000_0000, 4'hF, 2, 0, 3);
        // Lane 1 only: LED byte lane 0 untouched
        model_do_write(32'h0000_0000, 32'h0000_1234, 4'b0010, 0, 0, 0);
        check("led_strb", 32'(led_o), 32'h0);
        model_do_write(32'h0000_0000, 32'h0000_003C, 4'b0000, 0, 0, 0);
        check("led_strb0", 32'(led_o), 32'h0);
        model_do_write(32'h0000_0000, 32'hFFFF_FF5A, 4'b0001, 1, 1, 0);

        // RO write OKAY / unmapped write SLVERR, no effect
        model_do_write(32'h0000_0004, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
        model_do_write(32'h0000_0020, 32'hFFFF_FFFF, 4'hF, 0, 0, 1);

        // Button edge capture and W1C interplay
        set_buttons(5'b00100);
        model_check_read(32'h0000_000C, 0);
        check("edge_btn2", 32'(m_edge), 32'h4);
        press_with_w1c(5'b00101, 32'h0000_0004);
        model_check_read(32'h0000_000C, 0);
        check("edge_w1c_other", 32'(m_edge), 32'h1);
        press_with_w1c(5'b00111, 32'h0000_0002);
        model_check_read(32'h0000_000C, 1);
        check("edge_set_wins", 32'(m_edge), 32'h3);
        model_check_read(32'h0000_0008, 0);
        model_check_read(32'h0000_000C, 0);

        // Unmapped read with long rready stall; also the IRQ_EN slot
        axi_read(32'h0000_0020, 5, 32'h0, 2'b10);
        model_check_read(32'h0000_0010, 2);

`ifdef GPIO_IRQ_EN
        model_do_write(32'h0000_000C, 32'h0000_001F, 4'hF, 0, 0, 0);
        set_buttons(5'b00000);
        model_do_write(32'h0000_0010, 32'h0000_0001, 4'hF, 0, 0, 0);
        check("irq_idle", 32'(irq_o), 32'h0);
        set_buttons(5'b00001);
        check("irq_set", 32'(irq_o), 32'h1);
        model_do_write(32'h0000_000C, 32'h0000_0001, 4'hF, 0, 0, 0);
        check("irq_clear", 32'(irq_o), 32'h0);
`endif

        // Randomized traffic against the model
        for (int n = 0; n < 80; n++) begin
            addr_v = {8'($urandom), 16'($urandom), offs[$urandom_range(0, 7)]};
            addr_v[1:0] = 2'($urandom);
            case ($urandom_range(0, 4))
                0, 1: model_do_write(addr_v, $urandom, 4'($urandom), $urandom_range(0, 3),
                                     $urandom_range(0, 3), $urandom_range(0, 2));
                2: model_check_read(addr_v, $urandom_range(0, 3));
                3: begin
                    sw_i = SW_W'($urandom);
                    repeat (4) @(negedge aclk);
                    m_sw = sw_i;
                    model_check_read(32'h0000_0004, 0);
                end
                default: set_buttons(BTN_W'($urandom));
            endcase
`ifdef GPIO_IRQ_EN
            check("irq_rand", 32'(irq_o), 32'(|(m_edge & m_irq_en)));
`endif
        end
        model_check_read(32'h0000_000C, 0);

        // Reset in the middle of a write: held AW is dropped
        set_buttons(5'b00000);
        sw_i = '0;
        repeat (4) @(negedge aclk);
        bus.awvalid = 1'b1;
        bus.awaddr  = 32'h0000_0000;
        @(negedge aclk);
        bus.awvalid = 1'b0;
        check("mid_awready_held", 32'(bus.awready), 32'h0);
        areset = 1'b1;
        @(negedge aclk);
        @(negedge aclk);
        areset = 1'b0;
        model_reset();
        check("mid_awready", 32'(bus.awready), 32'h1);
        check("mid_bvalid", 32'(bus.bvalid), 32'h0);
        check("mid_led", 32'(led_o), 32'h0);
        model_check_read(32'h0000_000C, 0);
        model_do_write(32'h0000_0000, 32'h0000_0081, 4'hF, 0, 1, 0);
        model_check_read(32'h0000_0000, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
